// File: rtl/osd_dii_packet_buffer.sv
// Store-and-forward flit FIFO for one DII link, with a companion length FIFO
// that reports the flit count of the head packet.
module osd_dii_packet_buffer #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned LOG_SIZE   = 3,
    parameter int unsigned FULLPACKET = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    in_data,
    input  logic                in_last,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LOG_SIZE:0]   packet_size
);

    localparam int unsigned SIZE = 2 ** LOG_SIZE;
    localparam int unsigned CW   = LOG_SIZE + 1;
    localparam int unsigned DW   = WIDTH + 1;

    logic [DW-1:0]       flit_mem [SIZE];
    logic [CW-1:0]       len_mem  [SIZE];

    logic [LOG_SIZE-1:0] wr_ptr;
    logic [LOG_SIZE-1:0] rd_ptr;
    logic [LOG_SIZE-1:0] len_wr_ptr;
    logic [LOG_SIZE-1:0] len_rd_ptr;
    logic [CW-1:0]       count;
    logic [CW-1:0]       pkt_count;
    logic [CW-1:0]       cur_len;

    logic                full;
    logic                head_ok;
    logic                push;
    logic                pop;
    logic                pkt_in;
    logic                pkt_out;
    logic [DW-1:0]       head_flit;

    // Handshake decode from registered state; no combinational in->out path.
    always_comb begin
        full      = (count == CW'(SIZE));
        head_ok   = (FULLPACKET == 0) ? 1'b1 : ((pkt_count != '0) || full);
        in_ready  = !rst && !full;
        out_valid = (count != '0) && head_ok;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        pkt_in    = push && in_last;
        head_flit = flit_mem[rd_ptr];
        out_data  = out_valid ? head_flit[WIDTH-1:0] : '0;
        out_last  = out_valid ? head_flit[WIDTH] : 1'b0;
        pkt_out   = pop && out_last;
        packet_size = (pkt_count != '0) ? len_mem[len_rd_ptr] : '0;
    end

    // Flit storage; the write slot never aliases the head while it is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            flit_mem[wr_ptr] <= {in_last, in_data};
        end
    end

    // Length storage: one entry per completed packet.
    always_ff @(posedge clk) begin
        if (pkt_in) begin
            len_mem[len_wr_ptr] <= cur_len + CW'(1);
        end
    end

    // Pointers, occupancy and packet bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            len_wr_ptr <= '0;
            len_rd_ptr <= '0;
            count      <= '0;
            pkt_count  <= '0;
            cur_len    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + LOG_SIZE'(1);
                if (in_last) begin
                    len_wr_ptr <= len_wr_ptr + LOG_SIZE'(1);
                    cur_len    <= '0;
                end else begin
                    cur_len    <= cur_len + CW'(1);
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + LOG_SIZE'(1);
                if (out_last) begin
                    len_rd_ptr <= len_rd_ptr + LOG_SIZE'(1);
                end
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            case ({pkt_in, pkt_out})
                2'b10:   pkt_count <= pkt_count + CW'(1);
                2'b01:   pkt_count <= pkt_count - CW'(1);
                default: pkt_count <= pkt_count;
            endcase
        end
    end

endmodule
